sram_rd_sched: RTL and testbench
================================

SRAM_RD_SCHED -- requirements
Module: sram_rd_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the SRAM read port.
REQ-002 Parameter ADDR_W, default 10: SRAM word address width (1024 words).
REQ-003 Parameter DATA_W, default 8: SRAM word width.
REQ-004 Parameter LEN_W, default 4: burst length field width; burst = len+1 words (1..16).
REQ-005 The design SHALL have one clock and an asynchronous, active-low reset.
REQ-006 clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 req_i  input  NUM_REQ  per-requester burst request; held until granted.
REQ-009 addr_i  input  NUM_REQ*ADDR_W  per-requester start address; stable while req high.
REQ-010 len_i  input  NUM_REQ*LEN_W  per-requester burst length minus one; stable while req high.
REQ-011 gnt_o  output  NUM_REQ  one-hot acceptance strobe, combinational, at most one bit high.
REQ-012 sram_addr_o  output  ADDR_W  registered address driven to the SRAM read port.
REQ-013 sram_rdata_i  input  DATA_W  SRAM read data; settles within 4 ns of sram_addr_o change.
REQ-014 rdata_o  output  DATA_W  registered read data returned to the owning requester.
REQ-015 rvalid_o  output  1  rdata_o valid this cycle.
REQ-016 rid_o  output  log2(NUM_REQ)  index of the requester owning rdata_o.
REQ-017 rlast_o  output  1  high with the final beat of a burst.
REQ-018 busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE and BURST only.
REQ-020 gnt_o SHALL be asserted only in IDLE, to the round-robin winner among set req_i bits; acceptance = req_i[k] & gnt_o[k] at the rising edge.
REQ-021 Round-robin: search starts at pointer p; after acceptance of k, p <= (k+1) mod NUM_REQ; p unchanged when nothing is accepted.
REQ-022 On acceptance in cycle n: sram_addr_o <= addr_i[k], beat counter <= len_i[k], owner <= k, state <= BURST.
REQ-023 In BURST, one beat per cycle: beat j has sram_addr_o = start+j in cycle n+1+j.
REQ-024 Address increment SHALL wrap 1023 -> 0 (modulo 2^ADDR_W), no error.
REQ-025 On the beat where counter = 0, state <= IDLE; therefore BURST lasts len+1 cycles, and the next grant can occur no earlier than cycle n+2+len.
REQ-026 rdata_o SHALL capture sram_rdata_i at the end of each BURST cycle; beat j appears with rvalid_o=1 in cycle n+2+j; latency from acceptance to first data = 2 cycles.
REQ-027 rid_o and rlast_o SHALL be pipelined alongside rdata_o; rlast_o=1 only on beat len.
REQ-028 rvalid_o SHALL be 0 in every cycle not carrying a beat; rdata_o holds its last value when rvalid_o=0.
REQ-029 A requester dropping req_i before grant SHALL be ignored; no acceptance, no data.
REQ-030 req_i changes during BURST SHALL have no effect until IDLE.
REQ-031 sram_addr_o SHALL hold its value in IDLE.

Reset
REQ-032 reset_n low SHALL asynchronously force: state IDLE, p=0, sram_addr_o=0, rdata_o=0, rvalid_o=0, rid_o=0, rlast_o=0, busy_o=0, counter=0.
REQ-033 Reset mid-burst SHALL abort it: no further rvalid_o beats for that burst after reset release.
REQ-034 First grant after reset release SHALL favour requester 0 on simultaneous requests.

Structure
REQ-035 Package sram_ctrl_pkg SHALL hold NUM_REQ, ADDR_W, DATA_W, LEN_W defaults and the state enumeration.
REQ-036 Arbitration SHALL be a sub-module rr_arbiter (req vector + pointer -> one-hot grant + index).

Verification
REQ-037 After reset, req_i=4'b1111, all len=0 -> grants in order 0,1,2,3; one rvalid per burst, rid 0,1,2,3, rlast=1 each.
REQ-038 Requester 2, addr=1022, len=3 -> sram_addr_o 1022,1023,0,1 in consecutive cycles; rvalid 4 cycles, first 2 cycles after grant, rlast on 4th.
REQ-039 Preload SRAM[k]=k[7:0]; requester 1, addr=16, len=15 -> rdata_o 16..31, rid=1, no gaps.
REQ-040 Requester 0 holds req throughout while requester 3 requests -> grants alternate 0,3,0,3; no starvation.
REQ-041 Assert reset_n=0 at beat 5 of a 16-beat burst -> outputs zero immediately; after release, no residual rvalid_o.
REQ-042 Requester 1 pulses req for one cycle during BURST then drops -> never granted, no data for rid=1.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
// Module   : sram_ctrl_pkg
// Brief    : Shared defaults, state encoding and helpers for the SRAM read scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_W   = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } schedState_t;

  // A single requester still needs a one-bit index field.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin search from a start pointer; one-hot grant plus index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gntIdx,
  output logic               o_gntValid
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_gnt      = '0;
    o_gntIdx   = '0;
    o_gntValid = 1'b0;
    w_cand     = '0;
    w_found    = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_gnt[w_cand]   = 1'b1;
        o_gntIdx        = w_cand;
        o_gntValid      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_rd_sched.sv
// ============================================================================
// Module   : sram_rd_sched
// Brief    : Multi-requester burst read scheduler for a single-port SRAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rd_sched
  import sram_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int ADDR_W  = DEF_ADDR_W,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int LEN_W   = DEF_LEN_W,
  localparam int IDX_W   = idxWidth(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  len_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]         sram_addr_o,
  input  logic [DATA_W-1:0]         sram_rdata_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      rvalid_o,
  output logic [IDX_W-1:0]          rid_o,
  output logic                      rlast_o,
  output logic                      busy_o
);

  schedState_t        r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [LEN_W-1:0]   r_beatCnt;
  logic [ADDR_W-1:0]  r_sramAddr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;
  logic [IDX_W-1:0]   r_rid;
  logic               r_rlast;

  logic [NUM_REQ-1:0] w_arbGnt;
  logic [IDX_W-1:0]   w_arbIdx;
  logic               w_arbValid;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_selAddr;
  logic [LEN_W-1:0]   w_selLen;
  logic [IDX_W-1:0]   w_nextPtr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req      (req_i),
    .i_ptr      (r_ptr),
    .o_gnt      (w_arbGnt),
    .o_gntIdx   (w_arbIdx),
    .o_gntValid (w_arbValid)
  );

  // The arbiter only grants set request bits, so a valid grant in IDLE is an acceptance.
  assign w_accept  = (r_state == IDLE) && w_arbValid;
  assign gnt_o     = (r_state == IDLE) ? w_arbGnt : '0;
  assign w_selAddr = addr_i[w_arbIdx*ADDR_W +: ADDR_W];
  assign w_selLen  = len_i[w_arbIdx*LEN_W +: LEN_W];
  assign w_nextPtr = (w_arbIdx == IDX_W'(NUM_REQ - 1)) ? '0 : w_arbIdx + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_beatCnt  <= '0;
      r_sramAddr <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_rid      <= '0;
      r_rlast    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= BURST;
            r_sramAddr <= w_selAddr;
            r_beatCnt  <= w_selLen;
            r_owner    <= w_arbIdx;
            r_ptr      <= w_nextPtr;
          end
        end
        BURST: begin
          // Data for the address presented this cycle is captured at its end.
          r_rvalid <= 1'b1;
          r_rdata  <= sram_rdata_i;
          r_rid    <= r_owner;
          r_rlast  <= (r_beatCnt == '0);
          if (r_beatCnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_sramAddr <= r_sramAddr + 1'b1;
            r_beatCnt  <= r_beatCnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_addr_o = r_sramAddr;
  assign rdata_o     = r_rdata;
  assign rvalid_o    = r_rvalid;
  assign rid_o       = r_rid;
  assign rlast_o     = r_rlast;
  assign busy_o      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_rd_sched.sv
// ============================================================================
// Module   : tb_sram_rd_sched
// Brief    : Randomized and directed bench with a transaction-level schedule model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_rd_sched;
  import sram_ctrl_pkg::*;

  localparam int NR   = 4;
  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int LW   = 4;
  localparam int IW   = 2;
  localparam int MAXC = 6000;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NR-1:0]        req_i;
  logic [NR*AW-1:0]     addr_i;
  logic [NR*LW-1:0]     len_i;
  logic [NR-1:0]        gnt_o;
  logic [AW-1:0]        sram_addr_o;
  logic [DW-1:0]        sram_rdata_i;
  logic [DW-1:0]        rdata_o;
  logic                 rvalid_o;
  logic [IW-1:0]        rid_o;
  logic                 rlast_o;
  logic                 busy_o;

  logic [DW-1:0] mem [0:1023];

  always #5 clock = ~clock;
  assign sram_rdata_i = mem[sram_addr_o];

  sram_rd_sched #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LEN_W   (LW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_i        (req_i),
    .addr_i       (addr_i),
    .len_i        (len_i),
    .gnt_o        (gnt_o),
    .sram_addr_o  (sram_addr_o),
    .sram_rdata_i (sram_rdata_i),
    .rdata_o      (rdata_o),
    .rvalid_o     (rvalid_o),
    .rid_o        (rid_o),
    .rlast_o      (rlast_o),
    .busy_o       (busy_o)
  );

  int nCompared = 0;
  int nMismatch = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: observed %0d expected %0d (cycle model)", tag, obs, exp);
    end
  endtask

  // Expected per-cycle events, filled in when a burst is accepted.
  bit eAddrV [MAXC];
  int eAddr  [MAXC];
  bit eValid [MAXC];
  int eData  [MAXC];
  int eRid   [MAXC];
  bit eLast  [MAXC];

  int cyc      = 0;
  int idleFrom = 0;
  int mPtr     = 0;
  int curAddr  = 0;
  int curData  = 0;
  int rid1Cnt  = 0;
  int dutLog[$];

  logic [NR-1:0] sreq;
  logic [AW-1:0] sa [NR];
  logic [LW-1:0] sl [NR];

  task automatic driveInputs();
    for (int i = 0; i < NR; i++) begin
      addr_i[i*AW +: AW] = sa[i];
      len_i[i*LW +: LW]  = sl[i];
    end
    req_i = sreq;
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
    if (eAddrV[cyc]) curAddr = eAddr[cyc];
    checkEq("sram_addr", 32'(sram_addr_o), 32'(curAddr));
    checkEq("rvalid", 32'(rvalid_o), 32'(eValid[cyc]));
    checkEq("rlast", 32'(rlast_o), eValid[cyc] ? 32'(eLast[cyc]) : 32'd0);
    if (eValid[cyc]) begin
      curData = eData[cyc];
      checkEq("rid", 32'(rid_o), 32'(eRid[cyc]));
    end
    checkEq("rdata", 32'(rdata_o), 32'(curData));
    checkEq("busy", 32'(busy_o), 32'(cyc < idleFrom));
    if (rvalid_o && rid_o == 2'd1) rid1Cnt++;
  endtask

  task automatic evalCycle(input logic [NR-1:0] sticky);
    int win;
    int len;
    int ad;
    logic [NR-1:0] expGnt;
    driveInputs();
    #1;
    win    = -1;
    expGnt = '0;
    if (cyc >= idleFrom) begin
      for (int o = 0; o < NR; o++) begin
        if (win < 0 && sreq[(mPtr + o) % NR]) win = (mPtr + o) % NR;
      end
    end
    if (win >= 0) expGnt[win] = 1'b1;
    checkEq("gnt", 32'(gnt_o), 32'(expGnt));
    for (int i = 0; i < NR; i++) begin
      if (gnt_o[i] && req_i[i]) dutLog.push_back(i);
    end
    if (win >= 0) begin
      len = int'(sl[win]);
      for (int j = 0; j <= len; j++) begin
        ad = (int'(sa[win]) + j) % 1024;
        if (cyc + 2 + j < MAXC) begin
          eAddrV[cyc + 1 + j] = 1'b1;
          eAddr[cyc + 1 + j]  = ad;
          eValid[cyc + 2 + j] = 1'b1;
          eData[cyc + 2 + j]  = int'(mem[ad]);
          eRid[cyc + 2 + j]   = win;
          eLast[cyc + 2 + j]  = (j == len);
        end
      end
      idleFrom = cyc + 2 + len;
      mPtr     = (win + 1) % NR;
      if (!sticky[win]) sreq[win] = 1'b0;
    end
  endtask

  task automatic run(input int n, input logic [NR-1:0] sticky);
    for (int i = 0; i < n; i++) begin
      step();
      evalCycle(sticky);
    end
  endtask

  task automatic doReset();
    sreq    = '0;
    req_i   = '0;
    reset_n = 1'b0;
    #1;
    checkEq("rst_rvalid", 32'(rvalid_o), 32'd0);
    checkEq("rst_rdata", 32'(rdata_o), 32'd0);
    checkEq("rst_addr", 32'(sram_addr_o), 32'd0);
    checkEq("rst_rid", 32'(rid_o), 32'd0);
    checkEq("rst_rlast", 32'(rlast_o), 32'd0);
    checkEq("rst_busy", 32'(busy_o), 32'd0);
    for (int c = cyc + 1; c < MAXC; c++) begin
      eAddrV[c] = 1'b0;
      eValid[c] = 1'b0;
    end
    idleFrom = cyc;
    mPtr     = 0;
    curAddr  = 0;
    curData  = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic checkLog(input string tag, input int exp0, input int exp1,
                          input int exp2, input int exp3);
    int exp [4];
    exp = '{exp0, exp1, exp2, exp3};
    if (dutLog.size() < 4) begin
      checkEq({tag, "_count"}, 32'(dutLog.size()), 32'd4);
    end else begin
      for (int i = 0; i < 4; i++) checkEq(tag, 32'(dutLog[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = k[7:0];
    sreq = '0;
    for (int i = 0; i < NR; i++) begin
      sa[i] = '0;
      sl[i] = '0;
    end
    reset_n = 1'b0;
    driveInputs();
    repeat (3) @(posedge clock);
    #1;
    checkEq("init_rvalid", 32'(rvalid_o), 32'd0);
    checkEq("init_addr", 32'(sram_addr_o), 32'd0);
    checkEq("init_rdata", 32'(rdata_o), 32'd0);
    checkEq("init_busy", 32'(busy_o), 32'd0);
    checkEq("init_gnt", 32'(gnt_o), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // All four request single-word bursts together.
    dutLog.delete();
    for (int i = 0; i < NR; i++) begin
      sa[i] = AW'($urandom_range(0, 1023));
      sl[i] = '0;
    end
    sreq = 4'b1111;
    run(14, '0);
    checkLog("order0123", 0, 1, 2, 3);
    run(4, '0);

    // Address wrap across the top of memory.
    sa[2] = AW'(1022); sl[2] = LW'(3); sreq = 4'b0100;
    run(10, '0);

    // Long burst, full length.
    sa[1] = AW'(16); sl[1] = LW'(15); sreq = 4'b0010;
    run(22, '0);

    // Two persistent requesters must alternate.
    dutLog.delete();
    sa[0] = AW'(300); sl[0] = LW'(1);
    sa[3] = AW'(700); sl[3] = LW'(2);
    sreq = 4'b1001;
    run(40, 4'b1001);
    checkLog("alt03", 3, 0, 3, 0);
    sreq = '0;
    run(8, '0);

    // A short pulse during a burst must be ignored.
    rid1Cnt = 0;
    sa[0] = AW'(500); sl[0] = LW'(15); sreq = 4'b0001;
    run(4, '0);
    sa[1] = AW'(40); sl[1] = LW'(2); sreq[1] = 1'b1;
    run(1, '0);
    sreq[1] = 1'b0;
    run(24, '0);
    checkEq("no_rid1", 32'(rid1Cnt), 32'd0);

    // Reset in the middle of a 16-beat burst, at beat 5.
    sa[2] = AW'(200); sl[2] = LW'(15); sreq = 4'b0100;
    run(1, '0);
    run(7, '0);
    doReset();
    run(4, '0);
    dutLog.delete();
    for (int i = 0; i < NR; i++) sl[i] = '0;
    sreq = 4'b1111;
    run(12, '0);
    checkLog("post_rst", 0, 1, 2, 3);
    run(4, '0);

    // Random traffic with occasional withdrawn requests.
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (!sreq[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            sa[i]   = AW'($urandom_range(0, 1023));
            sl[i]   = LW'($urandom_range(0, 15));
            sreq[i] = 1'b1;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          sreq[i] = 1'b0;
        end
      end
      evalCycle('0);
    end
    sreq = '0;
    run(20, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

`default_nettype wire
